// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the ALU-sharing arbiter.
//   - arb_state_e : FSM state encodings (ARB_IDLE, ARB_EXEC, ARB_RESP)
//   - OP_*        : ALU operation codes; the arbiter passes these through untouched
//   - DATA_W/OP_W : operand/result and op-code widths
package alu_share_arb_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd7;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd8;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd9;
  localparam logic [OP_W-1:0] OP_OLUI = 4'd10;

endpackage

// File: rtl/alu_share_arb_rr_arbiter.sv
// Round-robin arbiter with an internal rotating priority pointer.
//   clk, rst  : clock and synchronous active-high reset (pointer -> 0)
//   req       : request vector, one bit per requester
//   advance   : the current grant was taken; move the pointer past it
//   grant     : one-hot winner (all zero when req is empty)
//   grant_id  : index of the winner
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W:0]   idx;
  logic [ID_W:0]   nxt;
  logic            found;

  // Walk upward from the pointer, wrapping at NUM_REQ; first set bit wins.
  // One extra bit of width keeps ptr+k from overflowing before the wrap.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req[idx[ID_W-1:0]]) begin
        found                = 1'b1;
        grant[idx[ID_W-1:0]] = 1'b1;
        grant_id             = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    nxt   = {1'b0, grant_id} + (ID_W+1)'(1);
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (nxt == (ID_W+1)'(NUM_REQ)) ? '0 : nxt[ID_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between NUM_REQ requesters.
//   req_valid/req_ready/req_op/req_a/req_b : per-requester request channels
//   rsp_valid/rsp_ready                    : per-requester response handshake
//   rsp_result/rsp_zero/rsp_id             : shared registered response payload
//   alu_operand1/2, alu_operation          : registered drive to the ALU
//   alu_result, alu_zero                   : ALU outputs, sampled at end of EXEC
// Flow: IDLE (grant + latch operands) -> EXEC (ALU settles) -> RESP (hold until
// owner accepts). Neither request nor response sees a path through the ALU.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           alu_operand1,
  output logic [31:0]           alu_operand2,
  output logic [3:0]            alu_operation,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               accept;

  logic [DATA_W-1:0] a_arr  [NUM_REQ];
  logic [DATA_W-1:0] b_arr  [NUM_REQ];
  logic [OP_W-1:0]   op_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign a_arr[gi]  = req_a[32*gi +: 32];
    assign b_arr[gi]  = req_b[32*gi +: 32];
    assign op_arr[gi] = req_op[4*gi +: 4];
  end

  // Grants are only offered in IDLE and never while reset is held.
  assign accept    = (state_q == ARB_IDLE) && !rst && (|grant);
  assign req_ready = ((state_q == ARB_IDLE) && !rst) ? grant : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .advance  (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rsp_id_d = rsp_id_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          op1_d   = a_arr[grant_id];
          op2_d   = b_arr[grant_id];
          op_d    = op_arr[grant_id];
          owner_d = grant_id;
          state_d = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        rsp_id_d = owner_q;
        state_d  = ARB_RESP;
      end
      ARB_RESP: begin
        // Only the owner's ready releases the response.
        if (rsp_ready[owner_q]) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == ARB_RESP) begin
      rsp_valid[rsp_id_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rsp_id_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rsp_id_q <= rsp_id_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign alu_operand1  = op1_q;
  assign alu_operand2  = op2_q;
  assign alu_operation = op_q;
  assign rsp_result    = result_q;
  assign rsp_zero      = zero_q;
  assign rsp_id        = rsp_id_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with two requesters and a small
// combinational ALU model hanging off the alu_* ports.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [0:0]  rsp_id;
  logic [31:0] alu_operand1;
  logic [31:0] alu_operand2;
  logic [3:0]  alu_operation;
  logic [31:0] alu_result;
  logic        alu_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arb #(
    .NUM_REQ (2),
    .ID_W    (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_zero      (rsp_zero),
    .rsp_id        (rsp_id),
    .alu_operand1  (alu_operand1),
    .alu_operand2  (alu_operand2),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero)
  );

  // Reference ALU: the external unit the arbiter feeds.
  always_comb begin
    alu_result = 32'h0;
    case (alu_operation)
      OP_ADD:  alu_result = alu_operand1 + alu_operand2;
      OP_SUB:  alu_result = alu_operand1 - alu_operand2;
      OP_AND:  alu_result = alu_operand1 & alu_operand2;
      OP_OR:   alu_result = alu_operand1 | alu_operand2;
      OP_XOR:  alu_result = alu_operand1 ^ alu_operand2;
      OP_SLL:  alu_result = alu_operand1 << alu_operand2[4:0];
      OP_SRL:  alu_result = alu_operand1 >> alu_operand2[4:0];
      OP_SRA:  alu_result = $unsigned($signed(alu_operand1) >>> alu_operand2[4:0]);
      OP_SLT:  alu_result = {31'h0, $signed(alu_operand1) < $signed(alu_operand2)};
      OP_SLTU: alu_result = {31'h0, alu_operand1 < alu_operand2};
      OP_OLUI: alu_result = alu_operand2;
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]     = v;
    req_op[4*i +: 4] = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // One isolated operation from requester i with rsp_ready high.
  task automatic do_op(input int i, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic exp_zero);
    set_req(i, 1'b1, op, a, b);
    #1;
    check("op_req_ready", 32'(req_ready), 32'(1 << i));
    step();
    set_req(i, 1'b0, op, a, b);
    check("op_exec_rsp_valid", 32'(rsp_valid), 32'h0);
    check("op_alu_operand1", alu_operand1, a);
    check("op_alu_operation", 32'(alu_operation), 32'(op));
    step();
    check("op_rsp_valid", 32'(rsp_valid), 32'(1 << i));
    check("op_rsp_result", rsp_result, exp_res);
    check("op_rsp_zero", 32'(rsp_zero), 32'(exp_zero));
    check("op_rsp_id", 32'(rsp_id), 32'(i));
    $display("txn req=%0d op=%0d a=%h b=%h result=%h zero=%0d", i, op, a, b, rsp_result, rsp_zero);
    step();
    check("op_rsp_drop", 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 2'b11;
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    step();
    step();
    // Reset state, with a request pending that must not be granted.
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_rsp_zero", 32'(rsp_zero), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_alu_operand1", alu_operand1, 32'h0);
    check("rst_alu_operand2", alu_operand2, 32'h0);
    check("rst_alu_operation", 32'(alu_operation), 32'h0);
    rst = 1'b0;
    set_req(0, 1'b0, OP_ADD, 32'd0, 32'd0);
    step();
    check("idle_no_req_ready", 32'(req_ready), 32'h0);

    // Single ops; pointer alternates 0 -> 1 -> 0 -> 1 -> 0.
    do_op(0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
    do_op(1, OP_SUB, 32'd9, 32'd9, 32'd0, 1'b1);
    do_op(0, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    do_op(1, 4'hF, 32'd3, 32'd4, 32'd0, 1'b1);
    check("alu_hold_operand1", alu_operand1, 32'd3);

    // Contention: both requesting continuously, grants alternate 0,1,0,1.
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    set_req(1, 1'b1, OP_XOR, 32'd3, 32'd3);
    for (int n = 0; n < 4; n++) begin
      #1;
      check("cont_req_ready", 32'(req_ready), 32'(1 << (n % 2)));
      step();
      step();
      check("cont_rsp_valid", 32'(rsp_valid), 32'(1 << (n % 2)));
      check("cont_rsp_id", 32'(rsp_id), 32'(n % 2));
      check("cont_rsp_result", rsp_result, (n % 2 == 0) ? 32'd2 : 32'd0);
      $display("txn contention n=%0d id=%0d result=%h", n, rsp_id, rsp_result);
      step();
    end
    req_valid = '0;

    // Back-pressure on requester 0 while requester 1 waits.
    rsp_ready = 2'b00;
    set_req(0, 1'b1, OP_ADD, 32'd10, 32'd20);
    set_req(1, 1'b1, OP_SUB, 32'd100, 32'd1);
    #1;
    check("bp_req_ready", 32'(req_ready), 32'h1);
    step();
    step();
    for (int n = 0; n < 5; n++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_result", rsp_result, 32'd30);
      check("bp_req_ready_low", 32'(req_ready), 32'h0);
      step();
    end
    rsp_ready = 2'b01;
    #1;
    check("bp_release_req_ready", 32'(req_ready), 32'h0);
    $display("txn backpressure id=%0d result=%h", rsp_id, rsp_result);
    step();
    check("bp_after_rsp_valid", 32'(rsp_valid), 32'h0);
    check("bp_after_req_ready", 32'(req_ready), 32'h2);
    req_valid[0] = 1'b0;
    step();
    step();
    // Wrong-owner ready: owner 1, only rsp_ready[0] asserted.
    for (int n = 0; n < 3; n++) begin
      check("wo_rsp_valid", 32'(rsp_valid), 32'h2);
      check("wo_rsp_id", 32'(rsp_id), 32'h1);
      check("wo_rsp_result", rsp_result, 32'd99);
      step();
    end
    rsp_ready    = 2'b10;
    req_valid[1] = 1'b0;
    $display("txn wrong_owner id=%0d result=%h", rsp_id, rsp_result);
    step();
    check("wo_release_rsp_valid", 32'(rsp_valid), 32'h0);
    rsp_ready = 2'b11;

    // Reset during EXEC: move pointer to 1 first, then discard an op.
    do_op(0, OP_ADD, 32'd1, 32'd2, 32'd3, 1'b0);
    set_req(0, 1'b1, OP_SUB, 32'd50, 32'd8);
    #1;
    check("mid_req_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rsp_result", rsp_result, 32'h0);
    check("mid_rsp_id", 32'(rsp_id), 32'h0);
    check("mid_alu_operand1", alu_operand1, 32'h0);
    check("mid_alu_operation", 32'(alu_operation), 32'h0);
    check("mid_req_ready_zero", 32'(req_ready), 32'h0);
    step();
    check("mid_no_response", 32'(rsp_valid), 32'h0);
    set_req(0, 1'b1, OP_AND, 32'h0000_00F0, 32'h0000_003C);
    set_req(1, 1'b1, OP_OR, 32'h1, 32'h2);
    #1;
    check("mid_ptr_reset_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();
    check("mid_post_rsp_result", rsp_result, 32'h30);
    check("mid_post_rsp_id", 32'(rsp_id), 32'h0);
    $display("txn post_reset id=%0d result=%h", rsp_id, rsp_result);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
